// File: rtl/fft_pkg.sv
// Shared types and constants for the 4-point FFT frame controller.
// Imported by fft_ctrl and by its bench.
package fft_pkg;

    localparam int NPOINTS = 4;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        CAPTURE = 2'd2,
        OUTPUT  = 2'd3
    } state_e;

endpackage

// File: rtl/fft_ctrl.sv
// Frame controller for a 4-point FFT engine: gathers samples, waits for
// the registered engine, captures its bins and streams them out in order.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_imag,
    output logic [WIDTH-1:0] eng_in_real  [0:NPOINTS-1],
    output logic [WIDTH-1:0] eng_in_imag  [0:NPOINTS-1],
    input  logic [WIDTH-1:0] eng_out_real [0:NPOINTS-1],
    input  logic [WIDTH-1:0] eng_out_imag [0:NPOINTS-1],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_real,
    output logic [WIDTH-1:0] out_imag,
    output logic [1:0]       out_idx,
    output logic             busy,
    output logic             frame_done
);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] sbuf_re_q [0:NPOINTS-1];
    logic [WIDTH-1:0] sbuf_im_q [0:NPOINTS-1];
    logic [WIDTH-1:0] rbuf_re_q [0:NPOINTS-1];
    logic [WIDTH-1:0] rbuf_im_q [0:NPOINTS-1];

    logic in_xfer;
    logic out_xfer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready   = (state_q == LOAD);
        out_valid  = (state_q == OUTPUT);
        in_xfer    = in_ready && in_valid;
        out_xfer   = out_valid && out_ready;
        busy       = !((state_q == LOAD) && (cnt_q == 2'd0));
        frame_done = out_xfer && (cnt_q == 2'd3) && !clear && rst_n;
        out_real   = '0;
        out_imag   = '0;
        out_idx    = 2'd0;
        if (out_valid) begin
            out_real = rbuf_re_q[cnt_q];
            out_imag = rbuf_im_q[cnt_q];
            out_idx  = cnt_q;
        end
        unique case (state_q)
            LOAD: begin
                if (in_xfer) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = COMPUTE;
                end
            end
            COMPUTE: state_d = CAPTURE;
            CAPTURE: state_d = OUTPUT;
            OUTPUT: begin
                if (out_xfer) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        // Abort beats the handshake: any beat in this cycle is dropped
        if (clear) begin
            state_d = LOAD;
            cnt_d   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NPOINTS; k++) begin
                sbuf_re_q[k] <= '0;
                sbuf_im_q[k] <= '0;
                rbuf_re_q[k] <= '0;
                rbuf_im_q[k] <= '0;
            end
        end else if (!clear) begin
            if (in_xfer) begin
                sbuf_re_q[cnt_q] <= in_real;
                sbuf_im_q[cnt_q] <= in_imag;
            end
            if (state_q == CAPTURE) begin
                for (int k = 0; k < NPOINTS; k++) begin
                    rbuf_re_q[k] <= eng_out_real[k];
                    rbuf_im_q[k] <= eng_out_imag[k];
                end
            end
        end
    end

    assign eng_in_real = sbuf_re_q;
    assign eng_in_imag = sbuf_im_q;

endmodule

// File: tb/tb_fft_ctrl.sv
// Bench for fft_ctrl: registered engine model, frame-level reference
// model and an output scoreboard.
module tb_fft_ctrl;
    import fft_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_real;
    logic [W-1:0] in_imag;
    logic [W-1:0] eng_in_real  [0:3];
    logic [W-1:0] eng_in_imag  [0:3];
    logic [W-1:0] eng_out_real [0:3];
    logic [W-1:0] eng_out_imag [0:3];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_real;
    logic [W-1:0] out_imag;
    logic [1:0]   out_idx;
    logic         busy;
    logic         frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] sb_re [$];
    logic [W-1:0] sb_im [$];
    logic [1:0]   sb_idx [$];

    always #5 clk = ~clk;

    fft_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .eng_in_real  (eng_in_real),
        .eng_in_imag  (eng_in_imag),
        .eng_out_real (eng_out_real),
        .eng_out_imag (eng_out_imag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_real     (out_real),
        .out_imag     (out_imag),
        .out_idx      (out_idx),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    // Engine stand-in: one register stage, bin k = in[k]+16k, -in[k]
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            eng_out_real[k] <= W'(eng_in_real[k] + W'(16 * k));
            eng_out_imag[k] <= W'(-eng_in_real[k]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Frame-level reference model
    int           m_nin = 0;
    int           m_nout = 0;
    int           m_wait = 0;
    bit           m_pend = 1'b0;
    bit           m_after_rst = 1'b0;
    logic [W-1:0] m_re [4] = '{default: '0};
    logic [W-1:0] m_im [4] = '{default: '0};

    always @(negedge clk) begin
        bit exp_ov;
        bit take_in;
        exp_ov  = m_pend && (m_wait == 0);
        take_in = !m_pend && in_valid;
        chk("in_ready", in_ready, !m_pend);
        chk("out_valid", out_valid, exp_ov);
        chk("busy", busy, m_pend || (m_nin > 0));
        chk("frame_done", frame_done,
            exp_ov && out_ready && (m_nout == 3) && !clear && rst_n);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("eng_in_real[%0d]", k), eng_in_real[k], m_re[k]);
            chk($sformatf("eng_in_imag[%0d]", k), eng_in_imag[k], m_im[k]);
        end
        if (m_after_rst) begin
            chk("rst out_real", out_real, 0);
            chk("rst out_imag", out_imag, 0);
            chk("rst out_idx", out_idx, 0);
        end
        m_after_rst = !rst_n;
        if (!rst_n || clear) begin
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    m_re[k] = '0;
                    m_im[k] = '0;
                end
            end
            m_nin  = 0;
            m_nout = 0;
            m_wait = 0;
            m_pend = 1'b0;
            sb_re.delete();
            sb_im.delete();
            sb_idx.delete();
        end else begin
            if (m_wait > 0) m_wait--;
            if (exp_ov && out_ready) begin
                m_nout++;
                if (m_nout == 4) begin
                    m_nout = 0;
                    m_pend = 1'b0;
                end
            end
            if (take_in) begin
                m_re[m_nin] = in_real;
                m_im[m_nin] = in_imag;
                m_nin++;
                if (m_nin == 4) begin
                    for (int k = 0; k < 4; k++) begin
                        sb_re.push_back(W'(m_re[k] + W'(16 * k)));
                        sb_im.push_back(W'(-m_re[k]));
                        sb_idx.push_back(2'(k));
                    end
                    m_nin  = 0;
                    m_pend = 1'b1;
                    m_wait = 2;
                end
            end
        end
    end

    // Output monitor: offered bin must match scoreboard head while held
    always @(negedge clk) begin
        if (rst_n && !clear && out_valid) begin
            if (sb_re.size() == 0) begin
                chk("unexpected bin", {30'd0, out_idx}, 32'hffff_ffff);
            end else begin
                chk("out_real", out_real, sb_re[0]);
                chk("out_imag", out_imag, sb_im[0]);
                chk("out_idx", out_idx, sb_idx[0]);
                if (out_ready) begin
                    void'(sb_re.pop_front());
                    void'(sb_im.pop_front());
                    void'(sb_idx.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [W-1:0] re,
                         input logic [W-1:0] im, input logic ordy,
                         input logic clr);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_real   = re;
        in_imag   = im;
        out_ready = ordy;
        clear     = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic       bp [10];
        logic [3:0] gap;
        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        in_real = '0;
        in_imag = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed frame (1,0)..(4,0)
        for (int i = 0; i < 4; i++) drive(1'b1, W'(i + 1), '0, 1'b1, 1'b0);
        idle(8);

        // Backpressure on bin 1
        bp = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 4; i++)
            drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, '0, '0, bp[i], 1'b0);
        idle(4);

        // Input gaps 1,0,0,1
        gap = 4'b1001;
        for (int i = 0; i < 16; i++)
            drive(gap[3 - (i % 4)], W'($urandom), W'($urandom), 1'b1, 1'b0);
        idle(10);

        // Clear after two samples, clear coincident with a beat
        for (int i = 0; i < 2; i++)
            drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
        drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1);
        idle(1);
        for (int i = 0; i < 4; i++)
            drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
        idle(10);

        // Reset during bin 2, in_valid held through COMPUTE/OUTPUT
        for (int i = 0; i < 8; i++)
            drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(12);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom % 4) != 0, W'($urandom), W'($urandom),
                  ($urandom % 3) != 0, ($urandom % 60) == 0);
            rst_n = ($urandom % 300) != 0;
        end
        rst_n = 1'b1;
        idle(20);
        @(negedge clk);
        chk("drain", sb_re.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample/result component width (signed two's complement).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port clear  input  1  synchronous frame abort.
REQ-005 SHALL have port in_valid  input  1  input sample offered.
REQ-006 SHALL have port in_ready  output  1  controller accepts sample.
REQ-007 SHALL have ports in_real, in_imag  input  WIDTH each  input sample components.
REQ-008 SHALL have ports eng_in_real[0:3], eng_in_imag[0:3]  output  WIDTH each  sample buffer driven to FFT engine.
REQ-009 SHALL have ports eng_out_real[0:3], eng_out_imag[0:3]  input  WIDTH each  engine results, bin k on index k.
REQ-010 SHALL have port out_valid  output  1  result bin offered.
REQ-011 SHALL have port out_ready  input  1  downstream accepts bin.
REQ-012 SHALL have ports out_real, out_imag  output  WIDTH each  result bin components.
REQ-013 SHALL have port out_idx  output  2  bin index of offered result.
REQ-014 SHALL have port busy  output  1  high in any state other than LOAD with zero samples held.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse when bin 3 is accepted.

Function
REQ-016 SHALL implement FSM states LOAD, COMPUTE, CAPTURE, OUTPUT.
REQ-017 LOAD: in_ready=1; a beat transfers when in_valid&&in_ready; sample stored at buffer[cnt]; cnt increments by 1.
REQ-018 LOAD->COMPUTE on the cycle the 4th sample (cnt=3) transfers; cnt wraps to 0.
REQ-019 COMPUTE: exactly one cycle; in_ready=0; buffer held stable so the engine's output register captures it on this cycle's edge.
REQ-020 CAPTURE: exactly one cycle; eng_out_real/imag[0:3] latched verbatim into a 4-entry result buffer; next state OUTPUT.
REQ-021 OUTPUT: out_valid=1; out_real/out_imag=result[cnt]; out_idx=cnt; bins emitted in natural order 0,1,2,3.
REQ-022 OUTPUT: cnt increments only when out_valid&&out_ready; out_real/out_imag/out_idx SHALL stay stable while out_ready=0.
REQ-023 OUTPUT->LOAD on acceptance of bin 3; frame_done=1 that cycle only; cnt=0.
REQ-024 Latency: first out_valid SHALL assert exactly 2 cycles after the edge transferring sample 3.
REQ-025 in_ready SHALL be 0 outside LOAD; samples offered then are not consumed; no overlap of frames.
REQ-026 eng_in_real/imag SHALL reflect the sample buffer at all times; buffer changes only in LOAD on transfers.
REQ-027 No arithmetic on data; values pass through unmodified at WIDTH bits.
REQ-028 clear=1 SHALL, from any state, return FSM to LOAD with cnt=0, out_valid=0, frame_done=0 next cycle; partial frame discarded; buffers not cleared.
REQ-029 clear coinciding with an input or output transfer: clear wins; transferred beat is discarded.
REQ-030 Throughput: a full frame SHALL take 10 cycles minimum with in_valid and out_ready held high.

Reset
REQ-031 On rst_n=0 at a clock edge: state=LOAD, cnt=0, in_ready=1 after reset, out_valid=0, frame_done=0, busy=0, out_idx=0, out_real/out_imag=0, sample and result buffers all 0.
REQ-032 Reset mid-frame SHALL behave as clear plus buffer zeroing; rst_n has priority over clear.

Structure
REQ-033 State enum (LOAD, COMPUTE, CAPTURE, OUTPUT) and constant NPOINTS=4 SHALL live in shared package fft_pkg.
REQ-034 Single module; fft_engine instantiated by the parent, not inside fft_ctrl; no sub-module required.

Verification
REQ-035 Bench SHALL model engine as 1-cycle registered map returning eng_out[k]=in[k]+16*k (real), -in[k] (imag).
REQ-036 Back-to-back frame: samples (1,0),(2,0),(3,0),(4,0), out_ready=1 -> bins (1,-1),(18,-2),(35,-3),(52,-4), idx 0..3, out_valid 2 cycles after 4th transfer, frame_done on bin 3.
REQ-037 Backpressure: out_ready low 3 cycles on bin 1 -> out_idx=1 and data held stable; no bin skipped or repeated.
REQ-038 Input gaps: in_valid toggling 1,0,0,1,... -> only valid beats stored; COMPUTE entered after 4th transfer only.
REQ-039 clear after 2 samples -> in_ready=1, busy=0 next cycle; following 4 samples produce correct frame.
REQ-040 rst_n low during OUTPUT bin 2 -> out_valid=0, outputs 0 next cycle; in_valid during COMPUTE never consumed (in_ready=0).
